// File: rtl/vram_write_arbiter.sv
// Single VRAM write port shared by a pixel requester and a rectangle-fill engine.
// Round-robin arbitration on contention, screen clipping, one registered write per clock.
module vram_write_arbiter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        vram_clk,
  input  logic        clrn,
  input  logic        px_req,
  input  logic [9:0]  px_x,
  input  logic [8:0]  px_y,
  input  logic [11:0] px_data,
  output logic        px_ack,
  input  logic        fill_start,
  input  logic [9:0]  fill_x0,
  input  logic [8:0]  fill_y0,
  input  logic [9:0]  fill_w,
  input  logic [8:0]  fill_h,
  input  logic [11:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        we,
  output logic [18:0] addr,
  output logic [11:0] data
);

  localparam logic [10:0] LP_W   = 11'(WIDTH);
  localparam logic [9:0]  LP_H   = 10'(HEIGHT);
  localparam logic [18:0] LP_W19 = 19'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x0;
  logic [10:0] r_xe;
  logic [9:0]  r_ye;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [18:0] r_row_base;
  logic [11:0] r_color;
  logic        r_rr_p;

  logic        w_fill_req;
  logic        w_grant_p;
  logic        w_grant_f;
  logic        w_x_end;
  logic        w_y_end;
  logic        w_fill_last;
  logic [10:0] w_sx_end;
  logic [9:0]  w_sy_end;
  logic [10:0] w_xe;
  logic [9:0]  w_ye;
  logic        w_empty;
  logic        w_px_ok;
  logic [18:0] w_px_addr;

  // Multiplication by the constant screen width reduces to shift-add (640 = 512 + 128).
  function automatic logic [18:0] f_row_base(input logic [8:0] y);
    f_row_base = 19'(y) * LP_W19;
  endfunction

  assign w_fill_req  = (r_state == ST_RUN);
  assign w_x_end     = (({1'b0, r_x} + 11'd1) == r_xe);
  assign w_y_end     = (({1'b0, r_y} + 10'd1) == r_ye);
  assign w_fill_last = w_grant_f & w_x_end & w_y_end;

  assign w_sx_end = {1'b0, fill_x0} + {1'b0, fill_w};
  assign w_sy_end = {1'b0, fill_y0} + {1'b0, fill_h};
  assign w_xe     = (w_sx_end > LP_W) ? LP_W : w_sx_end;
  assign w_ye     = (w_sy_end > LP_H) ? LP_H : w_sy_end;
  assign w_empty  = (fill_w == 10'd0) | (fill_h == 9'd0) |
                    ({1'b0, fill_x0} >= LP_W) | ({1'b0, fill_y0} >= LP_H);

  assign w_px_ok   = ({1'b0, px_x} < LP_W) & ({1'b0, px_y} < LP_H);
  assign w_px_addr = f_row_base(px_y) + 19'(px_x);

  // Grant is forced low while reset is asserted so px_ack reads 0 in reset.
  assign px_ack = w_grant_p & clrn;

  // Round-robin grant; r_rr_p set means the pixel port wins the next contest.
  always_comb begin
    w_grant_p = 1'b0;
    w_grant_f = 1'b0;
    if (px_req && w_fill_req) begin
      if (r_rr_p) begin
        w_grant_p = 1'b1;
      end else begin
        w_grant_f = 1'b1;
      end
    end else if (px_req) begin
      w_grant_p = 1'b1;
    end else if (w_fill_req) begin
      w_grant_f = 1'b1;
    end else begin
      w_grant_p = 1'b0;
    end
  end

  // Fill FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (fill_start) begin
          w_state_nxt = w_empty ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_fill_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fill FSM state register with registered busy/done flags.
  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= ST_IDLE;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      fill_busy <= (w_state_nxt != ST_IDLE);
      fill_done <= (w_state_nxt == ST_DONE);
    end
  end

  // Rectangle latch and cursor; row_base is stepped by WIDTH instead of re-multiplied.
  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      r_x0       <= 10'd0;
      r_xe       <= 11'd0;
      r_ye       <= 10'd0;
      r_x        <= 10'd0;
      r_y        <= 9'd0;
      r_row_base <= 19'd0;
      r_color    <= 12'd0;
    end else if ((r_state == ST_IDLE) && fill_start) begin
      r_x0       <= fill_x0;
      r_xe       <= w_xe;
      r_ye       <= w_ye;
      r_x        <= fill_x0;
      r_y        <= fill_y0;
      r_row_base <= f_row_base(fill_y0);
      r_color    <= fill_color;
    end else if (w_grant_f) begin
      if (w_x_end) begin
        r_x        <= r_x0;
        r_y        <= r_y + 9'd1;
        r_row_base <= r_row_base + LP_W19;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end else begin
      r_x <= r_x;
    end
  end

  // Round-robin pointer flips only when both requesters compete.
  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      r_rr_p <= 1'b1;
    end else if (px_req && w_fill_req) begin
      r_rr_p <= ~r_rr_p;
    end else begin
      r_rr_p <= r_rr_p;
    end
  end

  // Registered VRAM write port; address/data hold their last value when idle.
  always_ff @(posedge vram_clk or negedge clrn) begin
    if (!clrn) begin
      we   <= 1'b0;
      addr <= 19'd0;
      data <= 12'd0;
    end else begin
      we <= (w_grant_p & w_px_ok) | w_grant_f;
      if (w_grant_p && w_px_ok) begin
        addr <= w_px_addr;
        data <= px_data;
      end else if (w_grant_f) begin
        addr <= r_row_base + 19'(r_x);
        data <= r_color;
      end else begin
        addr <= addr;
        data <= data;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: table of per-cycle vectors plus
// hand sequences for contention and reset during a fill.
module tb_vram_write_arbiter;

  logic        vram_clk = 1'b0;
  logic        clrn;
  logic        px_req;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [11:0] px_data;
  logic        px_ack;
  logic        fill_start;
  logic [9:0]  fill_x0;
  logic [8:0]  fill_y0;
  logic [9:0]  fill_w;
  logic [8:0]  fill_h;
  logic [11:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        we;
  logic [18:0] addr;
  logic [11:0] data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        preq;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [11:0] pd;
    logic        fs;
    logic [9:0]  fx0;
    logic [8:0]  fy0;
    logic [9:0]  fw;
    logic [8:0]  fh;
    logic [11:0] fc;
    logic        e_ack;
    logic        e_we;
    logic [18:0] e_addr;
    logic [11:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vt[$];

  vram_write_arbiter #(.WIDTH(640), .HEIGHT(480)) dut (
    .vram_clk  (vram_clk),
    .clrn      (clrn),
    .px_req    (px_req),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_data   (px_data),
    .px_ack    (px_ack),
    .fill_start(fill_start),
    .fill_x0   (fill_x0),
    .fill_y0   (fill_y0),
    .fill_w    (fill_w),
    .fill_h    (fill_h),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .we        (we),
    .addr      (addr),
    .data      (data)
  );

  always #5 vram_clk = ~vram_clk;

  task automatic add(input logic preq, input logic [9:0] px, input logic [8:0] py,
                     input logic [11:0] pd, input logic fs, input logic [9:0] fx0,
                     input logic [8:0] fy0, input logic [9:0] fw, input logic [8:0] fh,
                     input logic [11:0] fc, input logic e_ack, input logic e_we,
                     input logic [18:0] e_addr, input logic [11:0] e_data,
                     input logic e_busy, input logic e_done);
    vec_t v;
    v = '{preq, px, py, pd, fs, fx0, fy0, fw, fh, fc, e_ack, e_we, e_addr, e_data, e_busy, e_done};
    vt.push_back(v);
  endtask

  task automatic drive(input logic preq, input logic [9:0] px, input logic [8:0] py,
                       input logic [11:0] pd, input logic fs, input logic [9:0] fx0,
                       input logic [8:0] fy0, input logic [9:0] fw, input logic [8:0] fh,
                       input logic [11:0] fc);
    px_req = preq; px_x = px; px_y = py; px_data = pd;
    fill_start = fs; fill_x0 = fx0; fill_y0 = fy0; fill_w = fw; fill_h = fh; fill_color = fc;
  endtask

  task automatic check(input string name, input logic e_ack, input logic e_we,
                       input logic [18:0] e_addr, input logic [11:0] e_data,
                       input logic e_busy, input logic e_done);
    n_vec++;
    if (px_ack !== e_ack || we !== e_we || addr !== e_addr || data !== e_data ||
        fill_busy !== e_busy || fill_done !== e_done) begin
      n_err++;
      $display("FAIL %s: got ack=%0b we=%0b addr=%0d data=%h busy=%0b done=%0b, want ack=%0b we=%0b addr=%0d data=%h busy=%0b done=%0b",
               name, px_ack, we, addr, data, fill_busy, fill_done,
               e_ack, e_we, e_addr, e_data, e_busy, e_done);
    end
  endtask

  initial begin
    logic        m_we;
    logic [18:0] m_addr;
    logic [11:0] m_data;
    int          p;
    int          f;
    logic        e_ack;

    clrn = 1'b0;
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);

    //   preq px      py      pd       fs    fx0      fy0     fw      fh     fc        ack   we    addr        data     busy  done
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd0,      12'h000, 1'b0, 1'b0);
    add(1'b1, 10'd5,  9'd2,   12'hF00, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b1, 1'b0, 19'd0,      12'h000, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd1285,   12'hF00, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd1285,   12'hF00, 1'b0, 1'b0);
    add(1'b1, 10'd700,9'd0,   12'h123, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b1, 1'b0, 19'd1285,   12'hF00, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd1285,   12'hF00, 1'b0, 1'b0);
    add(1'b1, 10'd0,  9'd479, 12'h00A, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b1, 1'b0, 19'd1285,   12'hF00, 1'b0, 1'b0);
    add(1'b1, 10'd639,9'd480, 12'h0BC, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b1, 1'b1, 19'd306560, 12'h00A, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd638, 9'd0,   10'd2,  9'd2,  12'h0F0,  1'b0, 1'b0, 19'd306560, 12'h00A, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd306560, 12'h00A, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd638,    12'h0F0, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd639,    12'h0F0, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd1278,   12'h0F0, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd1279,   12'h0F0, 1'b1, 1'b1);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd1279,   12'h0F0, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd639, 9'd479, 10'd10, 9'd10, 12'h555,  1'b0, 1'b0, 19'd1279,   12'h0F0, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd1279,   12'h0F0, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd307199, 12'h555, 1'b1, 1'b1);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd640, 9'd0,   10'd1,  9'd1,  12'h777,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b1, 1'b1);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd10,  9'd1,   10'd3,  9'd1,  12'h0AA,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd0,   9'd0,   10'd1,  9'd1,  12'hBBB,  1'b0, 1'b0, 19'd307199, 12'h555, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd0,   9'd0,   10'd1,  9'd1,  12'hBBB,  1'b0, 1'b1, 19'd650,    12'h0AA, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b1, 19'd651,    12'h0AA, 1'b1, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b1, 10'd0,   9'd0,   10'd1,  9'd1,  12'hBBB,  1'b0, 1'b1, 19'd652,    12'h0AA, 1'b1, 1'b1);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd652,    12'h0AA, 1'b0, 1'b0);
    add(1'b0, 10'd0,  9'd0,   12'h000, 1'b0, 10'd0,   9'd0,   10'd0,  9'd0,  12'h000,  1'b0, 1'b0, 19'd652,    12'h0AA, 1'b0, 1'b0);

    repeat (2) @(negedge vram_clk);
    clrn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge vram_clk);
      drive(vt[i].preq, vt[i].px, vt[i].py, vt[i].pd, vt[i].fs,
            vt[i].fx0, vt[i].fy0, vt[i].fw, vt[i].fh, vt[i].fc);
      #1;
      check($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_we, vt[i].e_addr,
            vt[i].e_data, vt[i].e_busy, vt[i].e_done);
    end

    // Contention: 4-pixel fill at row 10 (base 6400) with a pixel request held throughout.
    @(negedge vram_clk);
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b1, 10'd0, 9'd10, 10'd4, 9'd1, 12'h0C0);
    #1;
    check("cont_start", 1'b0, 1'b0, 19'd652, 12'h0AA, 1'b0, 1'b0);
    m_we = 1'b0; m_addr = 19'd652; m_data = 12'h0AA;
    p = 0; f = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge vram_clk);
      drive(1'b1, 10'(20 + p), 9'd0, 12'(12'h100 + p), 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);
      e_ack = (c % 2 == 1);
      #1;
      check($sformatf("cont_c%0d", c), e_ack, m_we, m_addr, m_data, 1'b1, 1'b0);
      m_we = 1'b1;
      if (e_ack) begin
        m_addr = 19'(20 + p); m_data = 12'(12'h100 + p); p++;
      end else begin
        m_addr = 19'(6400 + f); m_data = 12'h0C0; f++;
      end
    end
    @(negedge vram_clk);
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);
    #1;
    check("cont_done", 1'b0, 1'b1, 19'd6403, 12'h0C0, 1'b1, 1'b1);
    @(negedge vram_clk);
    #1;
    check("cont_idle", 1'b0, 1'b0, 19'd6403, 12'h0C0, 1'b0, 1'b0);

    // Reset in the middle of a 10-pixel fill.
    @(negedge vram_clk);
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b1, 10'd0, 9'd0, 10'd10, 9'd1, 12'h0F0);
    @(negedge vram_clk);
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);
    repeat (3) @(negedge vram_clk);
    #1;
    check("rst_pre", 1'b0, 1'b1, 19'd2, 12'h0F0, 1'b1, 1'b0);
    drive(1'b1, 10'd1, 9'd1, 12'h321, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);
    clrn = 1'b0;
    #1;
    check("rst_async", 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0);
    @(negedge vram_clk);
    drive(1'b0, 10'd0, 9'd0, 12'h0, 1'b0, 10'd0, 9'd0, 10'd0, 9'd0, 12'h0);
    clrn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge vram_clk);
      #1;
      check($sformatf("rst_post%0d", k), 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
